aux_reg_bridge: RTL
===================

AUX_REG_BRIDGE -- requirements
Module: aux_reg_bridge

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port aux_active, input, 1, high while the upstream USB/SPI bridge is in its aux opcode.
REQ-004 SHALL have port aux_complete, output, 1, one-cycle pulse ending the aux transaction.
REQ-005 SHALL have ports aux_rx_data, input, 8, and aux_rx_valid, input, 1: one host byte per valid pulse.
REQ-006 SHALL have port aux_rx_ready, output, 1, high while more host bytes are expected; drives the upstream aux_data_out_ready.
REQ-007 SHALL have ports aux_tx_data, output, 8, aux_tx_valid, output, 1, and aux_tx_ready, input, 1: reply byte toward the host.
REQ-008 SHALL have ports reg_addr, output, 8; reg_wdata, output, 8; reg_we, output, 1; reg_re, output, 1; reg_rdata, input, 8: register bus with rdata valid exactly 1 cycle after reg_re.

Function
REQ-009 SHALL decode a request of the form op, addr, len, then len data bytes for op 0x57 'W' only.
REQ-010 SHALL implement states IDLE, OP, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND, DONE, DRAIN.
REQ-011 IDLE -> OP when aux_active=1; otherwise SHALL stay in IDLE with all strobes low.
REQ-012 SHALL assert aux_rx_ready only in OP, ADDR, LEN and WDATA while aux_active=1; aux_rx_valid in any other state SHALL be ignored.
REQ-013 OP: on valid, SHALL latch the op byte; 'W' or 'R' (0x52) -> ADDR; any other value -> DONE with no bus access.
REQ-014 ADDR: on valid, SHALL load an 8-bit address counter -> LEN.
REQ-015 LEN: on valid, SHALL load an 8-bit remaining count; len=0 -> DONE; else 'W' -> WDATA, 'R' -> RREQ.
REQ-016 WDATA: on each valid byte, SHALL pulse reg_we for one cycle with the counter on reg_addr and the byte on reg_wdata, registered 1 cycle after the valid; count decrements; DONE after the last byte.
REQ-017 RREQ: SHALL pulse reg_re for one cycle with reg_addr = counter -> RWAIT.
REQ-018 RWAIT: SHALL capture reg_rdata into a tx holding register, assert aux_tx_valid -> RSEND.
REQ-019 RSEND: SHALL hold aux_tx_data and aux_tx_valid stable until aux_tx_ready=1; on the transfer cycle, count decrements and the counter increments; count reaches 0 -> DONE, else -> RREQ.
REQ-020 The address counter SHALL increment after every write or read byte and SHALL wrap 0xFF -> 0x00.
REQ-021 The count register SHALL be 8 bits; a request moves at most 255 bytes.
REQ-022 DONE: SHALL pulse aux_complete for exactly 1 cycle -> DRAIN.
REQ-023 DRAIN: SHALL hold until aux_active=0, then -> IDLE, so one transaction never triggers a second completion.
REQ-024 If aux_active falls in any state other than IDLE, DONE or DRAIN, the block SHALL abort to IDLE next cycle: no further reg strobes, aux_tx_valid low, no aux_complete.
REQ-025 reg_we and reg_re SHALL never be high in the same cycle; each SHALL be high for at most 1 cycle per byte.
REQ-026 Reply bytes SHALL never be dropped; while aux_tx_ready=0 the block SHALL stall with no extra reg_re.

Reset
REQ-027 When reset=1, state SHALL become IDLE and aux_complete, aux_rx_ready, aux_tx_valid, reg_we and reg_re SHALL be 0 on the next edge.
REQ-028 On reset, reg_addr, reg_wdata, aux_tx_data, the counter and the count SHALL be 0x00.
REQ-029 Reset SHALL override every other input in the same cycle, including reset mid-transaction.

Verification
REQ-030 Write test: aux_active=1, rx bytes 0x57,0x10,0x03,0xAA,0xBB,0xCC -> reg_we pulses at 0x10/AA, 0x11/BB, 0x12/CC; one aux_complete pulse.
REQ-031 Read test: rx 0x52,0xFE,0x03 with rdata = addr^0x5A, tx_ready always 1 -> reg_re at 0xFE,0xFF,0x00; tx bytes 0xA4,0xA5,0x5A; one complete pulse.
REQ-032 Backpressure test: read len 2 with tx_ready low for 5 cycles per byte -> tx_data stable while valid; exactly 2 reg_re pulses; 2 transfers.
REQ-033 Edge test: op 0x41, then a separate transaction 'W',0x00,0x00 -> each gives aux_complete after 1 or 3 bytes; no reg_we or reg_re.
REQ-034 Abort test: drop aux_active after the second data byte of a 4-byte write -> 2 reg_we only; no complete; next transaction works normally.
REQ-035 Reset test: assert reset during RSEND -> next cycle all strobes and valids are 0, state is IDLE.

Source files
------------

// File: rtl/aux_reg_bridge_if.sv
// Signal bundle between the upstream aux-opcode bridge / register file (master side)
// and aux_reg_bridge (slave side).
interface aux_reg_bridge_if;
    logic       aux_active;
    logic       aux_complete;
    logic [7:0] aux_rx_data;
    logic       aux_rx_valid;
    logic       aux_rx_ready;
    logic [7:0] aux_tx_data;
    logic       aux_tx_valid;
    logic       aux_tx_ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;

    modport slave (
        input  aux_active, aux_rx_data, aux_rx_valid, aux_tx_ready, reg_rdata,
        output aux_complete, aux_rx_ready, aux_tx_data, aux_tx_valid,
               reg_addr, reg_wdata, reg_we, reg_re
    );

    modport master (
        output aux_active, aux_rx_data, aux_rx_valid, aux_tx_ready, reg_rdata,
        input  aux_complete, aux_rx_ready, aux_tx_data, aux_tx_valid,
               reg_addr, reg_wdata, reg_we, reg_re
    );
endinterface

// File: rtl/aux_reg_bridge.sv
// Aux-opcode register bridge: decodes op/addr/len host requests into single-cycle
// register-bus strobes and streams read data back to the host one byte at a time.
module aux_reg_bridge (
    input  logic            clk,
    input  logic            reset,
    aux_reg_bridge_if.slave bus
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] OP    = 4'd1;
    localparam logic [3:0] ADDR  = 4'd2;
    localparam logic [3:0] LEN   = 4'd3;
    localparam logic [3:0] WDATA = 4'd4;
    localparam logic [3:0] RREQ  = 4'd5;
    localparam logic [3:0] RWAIT = 4'd6;
    localparam logic [3:0] RSEND = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;
    localparam logic [3:0] DRAIN = 4'd9;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    logic [3:0] state;
    logic [7:0] op;
    logic [7:0] addr_cnt;
    logic [7:0] count;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;

    logic in_request;
    logic rx_take;
    logic abort;

    assign in_request = (state == OP) || (state == ADDR) || (state == LEN) || (state == WDATA);
    assign rx_take    = bus.aux_rx_ready && bus.aux_rx_valid;
    // Losing aux_active mid-request drops the transaction; DONE/DRAIN finish on their own.
    assign abort      = !bus.aux_active && (state != IDLE) && (state != DONE) && (state != DRAIN);

    assign bus.aux_rx_ready = in_request && bus.aux_active;
    assign bus.aux_complete = (state == DONE);
    assign bus.aux_tx_data  = tx_data;
    assign bus.aux_tx_valid = tx_valid;
    assign bus.reg_addr     = reg_addr;
    assign bus.reg_wdata    = reg_wdata;
    assign bus.reg_we       = reg_we;
    assign bus.reg_re       = reg_re;

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values no matter how the statements below are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= 8'h00;
            addr_cnt  <= 8'h00;
            count     <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle, so a pulse can never stretch.
            reg_we <= 1'b0;
            reg_re <= 1'b0;

            if (abort) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.aux_active) state <= OP;
                    end

                    OP: begin
                        if (rx_take) begin
                            op <= bus.aux_rx_data;
                            if (bus.aux_rx_data == OP_WRITE || bus.aux_rx_data == OP_READ)
                                state <= ADDR;
                            else
                                state <= DONE;
                        end
                    end

                    ADDR: begin
                        if (rx_take) begin
                            addr_cnt <= bus.aux_rx_data;
                            state    <= LEN;
                        end
                    end

                    LEN: begin
                        if (rx_take) begin
                            count <= bus.aux_rx_data;
                            if (bus.aux_rx_data == 8'h00) begin
                                state <= DONE;
                            end else if (op == OP_WRITE) begin
                                state <= WDATA;
                            end else begin
                                // reg_re is issued on entry so it is high during RREQ and
                                // the read data lands during RWAIT.
                                state    <= RREQ;
                                reg_re   <= 1'b1;
                                reg_addr <= addr_cnt;
                            end
                        end
                    end

                    WDATA: begin
                        if (rx_take) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= addr_cnt;
                            reg_wdata <= bus.aux_rx_data;
                            addr_cnt  <= addr_cnt + 8'd1;
                            count     <= count - 8'd1;
                            if (count == 8'd1) state <= DONE;
                        end
                    end

                    RREQ: begin
                        state <= RWAIT;
                    end

                    RWAIT: begin
                        tx_data  <= bus.reg_rdata;
                        tx_valid <= 1'b1;
                        state    <= RSEND;
                    end

                    RSEND: begin
                        if (bus.aux_tx_ready) begin
                            tx_valid <= 1'b0;
                            addr_cnt <= addr_cnt + 8'd1;
                            count    <= count - 8'd1;
                            if (count == 8'd1) begin
                                state <= DONE;
                            end else begin
                                state    <= RREQ;
                                reg_re   <= 1'b1;
                                reg_addr <= addr_cnt + 8'd1;
                            end
                        end
                    end

                    DONE: begin
                        state <= DRAIN;
                    end

                    DRAIN: begin
                        if (!bus.aux_active) state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
